// File: rtl/traffic_light_multi.sv
// Multi-approach traffic light: round-robin green/yellow/all-red with flashing-red fail-safe; Moore outputs, IDLE->GREEN in one cycle.
// No backpressure: lamp outputs are free-running levels; Demand is sampled only in the last ALL_RED cycle.
module traffic_light_multi #(
    parameter int N_DIR      = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_HALF = 4,
    localparam int DIR_W     = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             Flash,
    input  logic [N_DIR-1:0] Demand,
    output logic [N_DIR-1:0] GREEN_EN,
    output logic [N_DIR-1:0] YELLOW_EN,
    output logic [N_DIR-1:0] RED_EN,
    output logic [DIR_W-1:0] Active_Dir,
    output logic             Phase_Start
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_ALL_RED,
        ST_FLASH
    } state_t;

    localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] F_LD  = CNT_W'(FLASH_HALF - 1);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] timer, nxt_timer;
    logic [DIR_W-1:0] dir, nxt_dir, sel_dir, cand;
    logic             blink, nxt_blink, found;
    logic [N_DIR-1:0] dir_oh;

    function automatic logic [DIR_W-1:0] inc_dir(input logic [DIR_W-1:0] d);
        return (d == DIR_W'(N_DIR - 1)) ? '0 : d + 1'b1;
    endfunction

    // First demanding approach after the current one; falls back to plain +1 so
    // the served approach never gets two greens in a row.
    always_comb begin
        sel_dir = inc_dir(dir);
        found   = 1'b0;
        cand    = dir;
        for (int k = 1; k < N_DIR; k++) begin
            cand = inc_dir(cand);
            if (!found && Demand[cand]) begin
                sel_dir = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
            timer <= '0;
            dir   <= '0;
            blink <= 1'b1;
        end else begin
            state <= nxt_state;
            timer <= nxt_timer;
            dir   <= nxt_dir;
            blink <= nxt_blink;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_timer = timer;
        nxt_dir   = dir;
        nxt_blink = blink;
        if (Flash) begin
            if (state != ST_FLASH) begin
                nxt_state = ST_FLASH;
                nxt_timer = F_LD;
                nxt_blink = 1'b1;
            end else if (timer == '0) begin
                nxt_timer = F_LD;
                nxt_blink = ~blink;
            end else begin
                nxt_timer = timer - 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Execute) begin
                        nxt_state = ST_GREEN;
                        nxt_timer = G_LD;
                    end
                end
                ST_GREEN: begin
                    if (timer == '0) begin
                        nxt_state = ST_YELLOW;
                        nxt_timer = Y_LD;
                    end else begin
                        nxt_timer = timer - 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (timer == '0) begin
                        nxt_state = ST_ALL_RED;
                        nxt_timer = AR_LD;
                    end else begin
                        nxt_timer = timer - 1'b1;
                    end
                end
                ST_ALL_RED: begin
                    if (timer != '0) begin
                        nxt_timer = timer - 1'b1;
                    end else if (Execute) begin
                        nxt_state = ST_GREEN;
                        nxt_timer = G_LD;
                        nxt_dir   = sel_dir;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_timer = '0;
                    end
                end
                ST_FLASH: begin
                    // Leaving fail-safe always goes through a full clearance interval.
                    nxt_state = ST_ALL_RED;
                    nxt_timer = AR_LD;
                    nxt_blink = 1'b1;
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_timer = '0;
                end
            endcase
        end
    end

    assign dir_oh     = {{(N_DIR-1){1'b0}}, 1'b1} << dir;
    assign Active_Dir = dir;

    always_comb begin
        GREEN_EN    = '0;
        YELLOW_EN   = '0;
        RED_EN      = '1;
        Phase_Start = 1'b0;
        case (state)
            ST_GREEN: begin
                GREEN_EN    = dir_oh;
                RED_EN      = ~dir_oh;
                Phase_Start = (timer == G_LD);
            end
            ST_YELLOW: begin
                YELLOW_EN = dir_oh;
                RED_EN    = ~dir_oh;
            end
            ST_FLASH: RED_EN = {N_DIR{blink}};
            default: ;
        endcase
    end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
- Parametrised successor to the single-approach red/yellow/green sequencer.
- Drives N_DIR mutually conflicting approaches with one-hot green, a yellow interval and an all-red clearance interval.
- Serves approaches in demand-aware round-robin, with per-phase durations set by parameters.
- Adds a flashing-red fail-safe mode. Sits between the board switch/sensor inputs and the lamp/LED output drivers.

Parameters:
- N_DIR, 2, number of approaches; legal range 2..8.
- CNT_W, 8, phase timer width.
- GREEN_CYC, 8, green duration in Clk cycles; legal range 1..2^CNT_W.
- YELLOW_CYC, 3, yellow duration in cycles; legal range 1..2^CNT_W.
- ALLRED_CYC, 2, all-red clearance in cycles; legal range 1..2^CNT_W.
- FLASH_HALF, 4, cycles per half-period of the flash blink; legal range 1..2^CNT_W.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset; Reset==0 at a rising edge resets the block.
- Execute  in  1  run enable; level-sensitive.
- Flash  in  1  fail-safe request; level-sensitive; overrides Execute.
- Demand  in  N_DIR  per-approach vehicle-present flags, sampled only at the end of ALL_RED.
- GREEN_EN  out  N_DIR  green lamp per approach; at most one bit high.
- YELLOW_EN  out  N_DIR  yellow lamp per approach; at most one bit high.
- RED_EN  out  N_DIR  red lamp per approach.
- Active_Dir  out  $clog2(N_DIR)  index of the approach currently (or last) served.
- Phase_Start  out  1  one-cycle pulse in the first cycle of each GREEN.

Behaviour:
- States: IDLE, GREEN, YELLOW, ALL_RED, FLASH.
- Outputs are Moore, decoded from registered state. They are valid in the same cycle the state is entered.
- Reset (Reset==0 at an edge): state is IDLE, timer 0, Active_Dir 0, blink 1, RED_EN all ones, GREEN_EN/YELLOW_EN 0, Phase_Start 0. Reset wins over Flash and Execute, including mid-phase.
- Priority each edge: Reset > Flash > normal transitions.
- IDLE:
  - All red, solid.
  - Execute==1 at an edge: next state GREEN with Active_Dir unchanged (0 after reset). Latency is one cycle.
- GREEN:
  - GREEN_EN[Active_Dir]=1; RED_EN=1 on all other approaches.
  - Timer loads GREEN_CYC-1 on entry and decrements each cycle; exit to YELLOW when timer==0.
  - GREEN therefore lasts exactly GREEN_CYC cycles.
  - Execute is ignored mid-phase.
- YELLOW:
  - YELLOW_EN[Active_Dir]=1; others red.
  - Lasts YELLOW_CYC cycles, then goes to ALL_RED.
- ALL_RED:
  - RED_EN all ones; lasts ALLRED_CYC cycles.
  - In the final cycle, if Execute==0, next state is IDLE and Active_Dir is held.
  - Otherwise next state is GREEN and Active_Dir becomes the first index j in the order Active_Dir+1, Active_Dir+2, ... (mod N_DIR), excluding Active_Dir itself, with Demand[j]==1.
  - If no other approach has demand, Active_Dir+1 mod N_DIR is selected regardless. A served approach therefore never gets two consecutive greens.
  - Index wrap: N_DIR-1 → 0.
- FLASH:
  - Entered on the edge after Flash==1 is seen in any non-reset state, abandoning the current phase immediately with no yellow.
  - GREEN_EN and YELLOW_EN are 0. RED_EN is all ones while blink==1, all zeros while blink==0.
  - Blink is 1 on entry and toggles every FLASH_HALF cycles.
  - When Flash==0 at an edge: next state is ALL_RED, timer reloaded, blink reset to 1. Normal exit rules from ALL_RED then apply.
- Phase_Start is high only in the first GREEN cycle.
- Invariant: GREEN_EN and YELLOW_EN are never both nonzero; no two approaches are ever non-red simultaneously.
- Timer is a CNT_W-bit down-counter, loaded on every state entry. No wrap is possible within legal parameters.

Test Plan:
- N_DIR=3, G=4, Y=2, AR=1, Demand=3'b111:
  - Drive Reset=0 for 2 cycles, then 1 → RED_EN=3'b111, Active_Dir=0.
  - Set Execute=1 → next cycle GREEN_EN=3'b001, Phase_Start=1 for 1 cycle.
  - Then 4 cycles green, 2 cycles YELLOW_EN=3'b001, 1 cycle all red, then GREEN_EN=3'b010.
- Demand=3'b100 while serving dir 0 → after ALL_RED, GREEN_EN=3'b100 (dir 1 skipped). Then Demand=3'b000 → next green is dir 0 (wrap).
- Drop Execute during GREEN of dir 1 → phase completes: 4 green, 2 yellow, 1 all red. Then IDLE with Active_Dir=1; re-assert Execute → GREEN_EN=3'b010.
- Raise Flash mid-YELLOW with FLASH_HALF=3 → next cycle GREEN_EN=YELLOW_EN=0 and RED_EN pattern 111,111,111,000,000,000 repeating. Drop Flash → 1 cycle all red, then next green per the demand rule.
- Drive Reset=0 mid-GREEN with Flash=1 → next cycle IDLE, RED_EN=3'b111, Active_Dir=0, blink=1, no flashing.
- Run 1000 random cycles of Execute, Flash and Demand with assertions: at most one non-red approach; GREEN_EN one-hot or zero; green length exactly G whenever the phase is not pre-empted by Flash.
